// File: rtl/vga_frame_fetch_if.sv
// Memory read bus and VGA FIFO write port used by the frame fetch engine.
// The engine side is the master; the memory/FIFO side is the slave.
interface vga_frame_fetch_if #(
   parameter int unsigned AW = 18,
   parameter int unsigned DW = 16
);
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ready;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] fifo_din;
   logic          fifo_write;
   logic          fifo_full;

   modport master (
      output mem_req, mem_addr, fifo_din, fifo_write,
      input  mem_ready, mem_rvalid, mem_rdata, fifo_full
   );

   modport slave (
      input  mem_req, mem_addr, fifo_din, fifo_write,
      output mem_ready, mem_rvalid, mem_rdata, fifo_full
   );
endinterface

// File: rtl/vga_frame_fetch.sv
// Framebuffer read engine: walks one frame linearly with single-word reads and
// pushes pixels in order into the VGA FIFO through a credit-limited skid buffer.
module vga_frame_fetch #(
   parameter int unsigned   AW         = 18,
   parameter int unsigned   DW         = 16,
   parameter int unsigned   H_DISPLAY  = 640,
   parameter int unsigned   V_DISPLAY  = 480,
   parameter logic [AW-1:0] BASE_ADDR  = '0,
   parameter int unsigned   SKID_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              frame_start,
   vga_frame_fetch_if.master bus,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err
);
   localparam int unsigned NPIX = H_DISPLAY * V_DISPLAY;
   localparam int unsigned RCW  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned IW   = $clog2(SKID_DEPTH);
   localparam int unsigned OW   = IW + 1;
   localparam int unsigned CW   = OW + 1;

   localparam logic [RCW-1:0] LAST_REQ = RCW'(NPIX - 1);
   localparam logic [CW-1:0]  CREDITS  = CW'(SKID_DEPTH);
   localparam logic [OW-1:0]  FULL_CNT = OW'(SKID_DEPTH);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e         state_q, state_d;
   logic [AW-1:0]  pix_addr_q, pix_addr_d;
   logic [RCW-1:0] req_cnt_q, req_cnt_d;
   logic [OW-1:0]  out_cnt_q, out_cnt_d;
   logic [IW:0]    wr_ptr_q, rd_ptr_q;
   logic [DW-1:0]  skid_q [SKID_DEPTH];
   logic           err_q;

   logic [OW-1:0]  skid_cnt;
   logic [CW-1:0]  in_flight;
   logic           accept;
   logic           rsp;
   logic           pop;

   // Outstanding reads plus buffered pixels never exceed the buffer size, so
   // every response has a slot even while the FIFO is full.
   assign skid_cnt  = wr_ptr_q - rd_ptr_q;
   assign in_flight = {1'b0, out_cnt_q} + {1'b0, skid_cnt};

   assign bus.mem_req    = (state_q == StFetch) && (in_flight < CREDITS);
   assign bus.mem_addr   = pix_addr_q;
   assign bus.fifo_write = (skid_cnt != '0) && !bus.fifo_full;
   assign bus.fifo_din   = skid_q[rd_ptr_q[IW-1:0]];

   assign accept = bus.mem_req && bus.mem_ready;
   assign rsp    = bus.mem_rvalid && (out_cnt_q != '0);
   assign pop    = bus.fifo_write;

   assign busy      = (state_q != StIdle);
   assign frame_err = err_q;

   always_comb begin
      state_d    = state_q;
      pix_addr_d = pix_addr_q;
      req_cnt_d  = req_cnt_q;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (frame_start && enable) begin
               state_d    = StFetch;
               pix_addr_d = BASE_ADDR;
               req_cnt_d  = '0;
            end
         end
         StFetch: begin
            if (accept) begin
               pix_addr_d = pix_addr_q + AW'(1);
               req_cnt_d  = req_cnt_q + RCW'(1);
               if (req_cnt_q == LAST_REQ) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if ((out_cnt_q == '0) && (skid_cnt == '0)) begin
               state_d    = StIdle;
               frame_done = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (accept && !rsp) begin
         out_cnt_d = out_cnt_q + OW'(1);
      end else if (rsp && !accept) begin
         out_cnt_d = out_cnt_q - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pix_addr_q <= BASE_ADDR;
         req_cnt_q  <= '0;
         out_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         err_q      <= 1'b0;
         for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
            skid_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         pix_addr_q <= pix_addr_d;
         req_cnt_q  <= req_cnt_d;
         out_cnt_q  <= out_cnt_d;
         wr_ptr_q   <= wr_ptr_q + {{IW{1'b0}}, rsp};
         rd_ptr_q   <= rd_ptr_q + {{IW{1'b0}}, pop};
         if (rsp) begin
            skid_q[wr_ptr_q[IW-1:0]] <= bus.mem_rdata;
         end
         if (frame_start && (state_q != StIdle)) begin
            err_q <= 1'b1;
         end
      end
   end

   a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.mem_req && !bus.mem_ready) |=> (bus.mem_req && $stable(bus.mem_addr)));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      (rsp && !pop) |-> (skid_cnt != FULL_CNT));
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Bench for vga_frame_fetch: table of frame scenarios plus hand sequences for
// reset abort, enable gating and address wrap; pixels checked via a scoreboard.
module tb_vga_frame_fetch;
   localparam int unsigned AW   = 18;
   localparam int unsigned DW   = 16;
   localparam int unsigned NPIX = 8;
   localparam int unsigned SKID = 4;
   localparam logic [AW-1:0] BASE_A = 18'h00010;
   localparam logic [7:0]    BASE_B = 8'hFE;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, enable, frame_start, ready_en, fifo_full;
   logic busy, frame_done, frame_err;
   logic b_start, b_busy, b_done, b_err;

   vga_frame_fetch_if #(.AW(AW), .DW(DW)) bus_a ();
   vga_frame_fetch_if #(.AW(8), .DW(8)) bus_b ();

   vga_frame_fetch #(
      .AW(AW), .DW(DW), .H_DISPLAY(4), .V_DISPLAY(2), .BASE_ADDR(BASE_A), .SKID_DEPTH(SKID)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start), .bus(bus_a),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
   );

   vga_frame_fetch #(
      .AW(8), .DW(8), .H_DISPLAY(2), .V_DISPLAY(2), .BASE_ADDR(BASE_B), .SKID_DEPTH(SKID)
   ) dut_wrap (
      .clk(clk), .rst(rst), .enable(1'b1), .frame_start(b_start), .bus(bus_b),
      .busy(b_busy), .frame_done(b_done), .frame_err(b_err)
   );

   function automatic logic [15:0] pix_of(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   // Memory model for the main DUT: always accepts when ready_en, fixed latency.
   int unsigned   lat = 2;
   logic [5:0]    pv = '0;
   logic [AW-1:0] pa [6];
   always @(posedge clk) begin
      pv    <= {pv[4:0], bus_a.mem_req && bus_a.mem_ready};
      pa[0] <= bus_a.mem_addr;
      for (int i = 1; i < 6; i++) pa[i] <= pa[i-1];
   end
   assign bus_a.mem_ready  = ready_en;
   assign bus_a.mem_rvalid = pv[lat-1];
   assign bus_a.mem_rdata  = pix_of(pa[lat-1]);
   assign bus_a.fifo_full  = fifo_full;

   // Wrap DUT memory: always ready, one-cycle latency, FIFO never full.
   logic       b_pv = 1'b0;
   logic [7:0] b_pa;
   always @(posedge clk) begin
      b_pv <= bus_b.mem_req;
      b_pa <= bus_b.mem_addr;
   end
   assign bus_b.mem_ready  = 1'b1;
   assign bus_b.mem_rvalid = b_pv;
   assign bus_b.mem_rdata  = b_pa ^ 8'h3C;
   assign bus_b.fifo_full  = 1'b0;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model state for the main DUT.
   logic [15:0]   exp_q [$];
   logic [AW-1:0] exp_addr = BASE_A;
   logic [AW-1:0] prev_addr;
   int  acc_total = 0, rsp_total = 0, push_total = 0;
   int  frame_acc = 0, frame_push = 0, done_cnt = 0;
   bit  fr_active = 0, err_model = 0, prev_stall = 0;

   task automatic clear_model();
      exp_q.delete();
      exp_addr   = BASE_A;
      acc_total  = 0;
      rsp_total  = 0;
      push_total = 0;
      frame_acc  = 0;
      frame_push = 0;
      done_cnt   = 0;
      fr_active  = 0;
      err_model  = 0;
      prev_stall = 0;
   endtask

   always @(negedge clk) begin
      int occ, bufd, outs;
      bit fa, exp_done;
      if (!rst) begin
         fa       = fr_active;
         occ      = acc_total - push_total;
         bufd     = rsp_total - push_total;
         outs     = acc_total - rsp_total;
         exp_done = fa && (frame_acc == NPIX) && (occ == 0);
         check("busy", busy, fa);
         check("mem_req", bus_a.mem_req, fa && (frame_acc < NPIX) && (occ < SKID));
         check("frame_done", frame_done, exp_done);
         check("frame_err", frame_err, err_model);
         check("fifo_write", bus_a.fifo_write, (bufd > 0) && !fifo_full);
         if (prev_stall) check("addr_hold", bus_a.mem_addr, prev_addr);
         if (bus_a.mem_rvalid && outs > 0) rsp_total++;
         if (bus_a.mem_req && bus_a.mem_ready) begin
            check("mem_addr", bus_a.mem_addr, exp_addr);
            exp_q.push_back(pix_of(exp_addr));
            exp_addr++;
            frame_acc++;
            acc_total++;
         end
         if (bus_a.fifo_write) begin
            if (exp_q.size() == 0) check("stray_push", bus_a.fifo_write, 0);
            else check("pixel", bus_a.fifo_din, exp_q.pop_front());
            push_total++;
            frame_push++;
         end
         prev_stall = bus_a.mem_req && !bus_a.mem_ready;
         prev_addr  = bus_a.mem_addr;
         if (frame_done) done_cnt++;
         if (frame_start && fa) err_model = 1;
         if (exp_done) fr_active = 0;
         if (frame_start && enable && !fa) begin
            fr_active  = 1;
            frame_acc  = 0;
            frame_push = 0;
            done_cnt   = 0;
            exp_addr   = BASE_A;
         end
      end
   end

   // Scoreboard for the wrap DUT.
   logic [7:0] b_q [$];
   logic [7:0] b_exp_addr = BASE_B;
   int b_acc = 0, b_push = 0, b_done_cnt = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_b.mem_req) begin
            check("wrap_addr", bus_b.mem_addr, b_exp_addr);
            b_q.push_back(b_exp_addr ^ 8'h3C);
            b_exp_addr++;
            b_acc++;
         end
         if (bus_b.fifo_write) begin
            if (b_q.size() == 0) check("wrap_stray_push", bus_b.fifo_write, 0);
            else check("wrap_pixel", bus_b.fifo_din, b_q.pop_front());
            b_push++;
         end
         if (b_done) b_done_cnt++;
      end
   end

   typedef struct {
      int fill_at;
      int fill_len;
      int stall_at;
      int stall_len;
      int dup_at;
      int en_off_at;
      int exp_pushes;
      bit exp_err;
   } frame_vec_t;

   frame_vec_t vecs [7];

   task automatic run_frame(input frame_vec_t v, input int idx);
      bit finished;
      string tag;
      finished = 0;
      tag = $sformatf("row%0d", idx);
      for (int c = 0; c < 300 && !finished; c++) begin
         @(posedge clk); #1;
         frame_start = (c == 0) || (v.dup_at != 0 && c == v.dup_at);
         enable      = !(v.en_off_at != 0 && c >= v.en_off_at);
         fifo_full   = (c >= v.fill_at) && (c < v.fill_at + v.fill_len);
         ready_en    = !((c >= v.stall_at) && (c < v.stall_at + v.stall_len));
         @(negedge clk); #1;
         if (!fr_active) finished = 1;
      end
      frame_start = 0;
      fifo_full   = 0;
      ready_en    = 1;
      enable      = 1;
      repeat (2) @(negedge clk);
      check({tag, "_finished"}, finished, 1);
      check({tag, "_pushes"}, frame_push, v.exp_pushes);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_left_in_sb"}, exp_q.size(), 0);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_err"}, frame_err, v.exp_err);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      rst = 1; enable = 1; frame_start = 0; ready_en = 1; fifo_full = 0; b_start = 0;
      //           fill_at len stall_at len dup en_off pushes err
      vecs[0] = '{0, 0,  0, 0, 0, 0, NPIX, 0};
      vecs[1] = '{3, 20, 0, 0, 0, 0, NPIX, 0};
      vecs[2] = '{0, 0,  2, 5, 0, 0, NPIX, 0};
      vecs[3] = '{1, 6,  4, 3, 0, 2, NPIX, 0};
      vecs[4] = '{0, 0,  0, 0, 3, 0, NPIX, 1};
      vecs[5] = '{0, 0,  0, 0, 0, 0, NPIX, 1};
      vecs[6] = '{0, 0,  0, 0, 0, 0, NPIX, 0};

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("rst_mem_req", bus_a.mem_req, 0);
      check("rst_mem_addr", bus_a.mem_addr, BASE_A);
      check("rst_fifo_write", bus_a.fifo_write, 0);
      check("rst_fifo_din", bus_a.fifo_din, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);

      // frame_start without enable must not start a frame
      @(posedge clk); #1; enable = 0; frame_start = 1;
      @(posedge clk); #1; enable = 1; frame_start = 0;
      @(negedge clk);
      check("enable_gate", busy, 0);

      // Address wrap: BASE = 2^AW-2 on the 8-bit DUT
      @(posedge clk); #1; b_start = 1;
      @(posedge clk); #1; b_start = 0;
      for (int c = 0; c < 40 && b_done_cnt == 0; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("wrap_accepts", b_acc, 4);
      check("wrap_pushes", b_push, 4);
      check("wrap_done", b_done_cnt, 1);
      check("wrap_busy", b_busy, 0);
      check("wrap_err", b_err, 0);

      for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

      // Reset with reads in flight; late responses must be dropped
      lat = 4;
      @(posedge clk); #1; frame_start = 1;
      @(posedge clk); #1; frame_start = 0;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge clk); #1;
         if (acc_total - rsp_total >= 3) hit = 1;
      end
      check("three_outstanding", hit, 1);
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0;
      clear_model();
      @(negedge clk);
      check("abort_mem_req", bus_a.mem_req, 0);
      check("abort_mem_addr", bus_a.mem_addr, BASE_A);
      check("abort_fifo_write", bus_a.fifo_write, 0);
      check("abort_fifo_din", bus_a.fifo_din, 0);
      check("abort_busy", busy, 0);
      check("abort_frame_err", frame_err, 0);
      repeat (12) @(negedge clk);
      lat = 2;

      run_frame(vecs[6], 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
